// File: rtl/shift_add_acc.sv
// Accumulator for the shift-and-add multiplier: load, add or logical right-shift, priority Load > Ad > Sh.
// Optional carry-out flag Co is built only when ACC_CARRY_OUT_EN is defined.
module shift_add_acc #(
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic             Sh,
  input  logic             Ad,
  input  logic [WIDTH-1:0] Entradas,
  output logic [WIDTH-1:0] Saidas
`ifdef ACC_CARRY_OUT_EN
  ,
  output logic             Co
`endif
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             acc_en;

`ifdef ACC_CARRY_OUT_EN
  logic [WIDTH:0] sum;
  logic           co_q;
  logic           co_d;

  assign sum = {1'b0, acc_q} + {1'b0, Entradas};
`else
  logic [WIDTH-1:0] sum;

  assign sum = acc_q + Entradas;
`endif

  // Hold is an explicit enable, so idle cycles never look at Entradas.
  always_comb begin
    acc_en = Load | Ad | Sh;
    acc_d  = acc_q;
    if (Load) begin
      acc_d = Entradas;
    end else if (Ad) begin
      acc_d = sum[WIDTH-1:0];
    end else if (Sh) begin
      acc_d = {1'b0, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_d;
    end
  end

  assign Saidas = acc_q;

`ifdef ACC_CARRY_OUT_EN
  // Only a winning Ad reports a carry; Load and Sh clear it.
  always_comb begin
    co_d = 1'b0;
    if (!Load && Ad) begin
      co_d = sum[WIDTH];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      co_q <= 1'b0;
    end else if (acc_en) begin
      co_q <= co_d;
    end
  end

  assign Co = co_q;
`endif

endmodule

// File: tb/tb_shift_add_acc.sv
// Directed bench for shift_add_acc: inputs change on negedge, outputs are checked on the following negedge.
// Co checks are compiled in only when ACC_CARRY_OUT_EN is defined.
module tb_shift_add_acc;
  localparam int WIDTH = 9;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic             sh;
  logic             ad;
  logic [WIDTH-1:0] entradas;
  logic [WIDTH-1:0] saidas;
`ifdef ACC_CARRY_OUT_EN
  logic             co;
`endif

  int total;
  int bad;

  shift_add_acc #(.WIDTH(WIDTH)) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Load     (load),
    .Sh       (sh),
    .Ad       (ad),
    .Entradas (entradas),
    .Saidas   (saidas)
`ifdef ACC_CARRY_OUT_EN
    ,
    .Co       (co)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic l, input logic a, input logic s, input logic [WIDTH-1:0] e);
    load     = l;
    ad       = a;
    sh       = s;
    entradas = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // checkers
  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_co(input string tag, input logic exp);
`ifdef ACC_CARRY_OUT_EN
    total++;
    assert (co === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, co, exp);
    end
`else
    if (tag.len() > 0 && exp !== 1'bx) begin
      // carry flag absent in this build
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);

    // asynchronous reset assertion before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", saidas, 9'd0);
    chk_co("reset_async_co", 1'b0);

    // commands presented while in reset must be ignored across edges
    drive(1'b1, 1'b0, 1'b0, 9'd9);
    @(negedge clk);
    cyc();
    cyc();
    chk("reset_hold", saidas, 9'd0);

    // release and load
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 9'd7);
    cyc();
    chk("load_7", saidas, 9'd7);
    chk_co("load_7_co", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 9'd100);
    cyc();
    chk("hold_7", saidas, 9'd7);

    // shifts, Entradas ignored
    drive(1'b0, 1'b0, 1'b1, 9'd1);
    cyc();
    chk("shift_7_to_3", saidas, 9'd3);
    cyc();
    chk("shift_3_to_1", saidas, 9'd1);
    cyc();
    chk("shift_1_to_0", saidas, 9'd0);
    cyc();
    chk("shift_0_to_0", saidas, 9'd0);

    // add with wrap
    drive(1'b1, 1'b0, 1'b0, 9'd3);
    cyc();
    chk("load_3", saidas, 9'd3);
    drive(1'b0, 1'b1, 1'b0, 9'd200);
    cyc();
    chk("add_200", saidas, 9'd203);
    chk_co("add_200_co", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 9'd400);
    cyc();
    chk("add_400_wrap", saidas, 9'd91);
    chk_co("add_400_co", 1'b1);

    // priority
    drive(1'b1, 1'b0, 1'b0, 9'd203);
    cyc();
    chk("load_203", saidas, 9'd203);
    chk_co("load_clears_co", 1'b0);
    drive(1'b1, 1'b1, 1'b1, 9'd5);
    cyc();
    chk("prio_load", saidas, 9'd5);
    chk_co("prio_load_co", 1'b0);
    drive(1'b0, 1'b1, 1'b1, 9'd2);
    cyc();
    chk("prio_add_over_shift", saidas, 9'd7);
    chk_co("prio_add_co", 1'b0);

    // set carry, then hold with random data
    drive(1'b0, 1'b1, 1'b0, 9'd511);
    cyc();
    chk("add_511", saidas, 9'd6);
    chk_co("add_511_co", 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, WIDTH'($urandom_range(0, 511)));
      cyc();
      chk($sformatf("hold_rand_%0d", i), saidas, 9'd6);
      chk_co($sformatf("hold_rand_co_%0d", i), 1'b1);
    end

    // 511 + 1 wraps to 0
    drive(1'b1, 1'b0, 1'b0, 9'd511);
    cyc();
    chk("load_511", saidas, 9'd511);
    drive(1'b0, 1'b1, 1'b0, 9'd1);
    cyc();
    chk("wrap_511_plus_1", saidas, 9'd0);
    chk_co("wrap_co", 1'b1);

    // reset mid-cycle aborts a pending load
    drive(1'b1, 1'b0, 1'b0, 9'd7);
    cyc();
    chk("load_7_again", saidas, 9'd7);
    drive(1'b1, 1'b0, 1'b0, 9'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_cycle", saidas, 9'd0);
    chk_co("reset_mid_cycle_co", 1'b0);
    @(negedge clk);
    cyc();
    chk("reset_abort_pending", saidas, 9'd0);

    // first update on first posedge after release
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 9'd85);
    cyc();
    chk("release_first_edge", saidas, 9'd85);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
